// File: rtl/intc_arb_pkg.sv
// Shared definitions for the interrupt-controller APB arbiter.
//   CPU_NUM      : default number of APB requesters (overridable macro)
//   TMO_CYC_DEF  : default ACCESS-phase cycle budget before a transfer is aborted
//   arb_state_e  : arbiter FSM state encoding
`ifndef CPU_NUM
`define CPU_NUM 2
`endif

package intc_arb_pkg;

   localparam int unsigned TMO_CYC_DEF = 256;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } arb_state_e;

endpackage

// File: rtl/rr_arb.sv
// Round-robin winner selection, purely combinational.
//   req     : request vector, one bit per requester
//   ptr     : index where the search starts; the search wraps modulo MST_NUM
//   gnt_oh  : one-hot winner (all zero when no request)
//   gnt_idx : index of the winner (0 when no request)
module rr_arb #(
   parameter int unsigned MST_NUM = 2,
   parameter int unsigned IW      = (MST_NUM > 1) ? $clog2(MST_NUM) : 1
) (
   input  logic [MST_NUM-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [MST_NUM-1:0] gnt_oh,
   output logic [IW-1:0]      gnt_idx
);

   always_comb begin
      int unsigned j;
      logic        found;
      j       = 0;
      found   = 1'b0;
      gnt_oh  = '0;
      gnt_idx = '0;
      for (int unsigned i = 0; i < MST_NUM; i++) begin
         j = (32'(ptr) + i) % MST_NUM;
         if (!found && req[j]) begin
            found      = 1'b1;
            gnt_oh[j]  = 1'b1;
            gnt_idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/intc_apb_arb.sv
// Multi-requester APB arbiter in front of the interrupt-controller register port.
//   clk, rst                       : clock, synchronous active-high reset
//   m_psel/m_penable/m_pwrite      : per-requester APB controls
//   m_paddr/m_pwdata/m_pstrb       : per-requester address/data/strobes, packed by index
//   m_prdata                       : read data, broadcast to all requesters
//   m_pready/m_pslverr             : per-requester completion and error
//   s_psel..s_pstrb                : single APB master port toward the controller
//   s_prdata/s_pready/s_pslverr    : slave response
// A transfer that sits in ACCESS for TMO_CYC cycles without s_pready is completed
// toward the requester with an error and the slave port is released.
`ifndef CPU_NUM
`define CPU_NUM 2
`endif

module intc_apb_arb
   import intc_arb_pkg::*;
#(
   parameter int unsigned MST_NUM = `CPU_NUM,
   parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MST_NUM-1:0]   m_psel,
   input  logic [MST_NUM-1:0]   m_penable,
   input  logic [MST_NUM-1:0]   m_pwrite,
   input  logic [MST_NUM*32-1:0] m_paddr,
   input  logic [MST_NUM*32-1:0] m_pwdata,
   input  logic [MST_NUM*4-1:0] m_pstrb,
   output logic [31:0]          m_prdata,
   output logic [MST_NUM-1:0]   m_pready,
   output logic [MST_NUM-1:0]   m_pslverr,
   output logic                 s_psel,
   output logic                 s_penable,
   output logic                 s_pwrite,
   output logic [31:0]          s_paddr,
   output logic [31:0]          s_pwdata,
   output logic [3:0]           s_pstrb,
   input  logic [31:0]          s_prdata,
   input  logic                 s_pready,
   input  logic                 s_pslverr
);

   localparam int unsigned IW = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
   localparam int unsigned CW = $clog2(TMO_CYC) + 1;

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      grant_q, grant_d;
   logic [MST_NUM-1:0] grant_oh_q, grant_oh_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [CW-1:0]      tmo_cnt_q, tmo_cnt_d;

   logic [MST_NUM-1:0] win_oh;
   logic [IW-1:0]      win_idx;
   logic               in_access;
   logic               timeout;
   logic               done;

   // The grant decision is taken once in IDLE; m_penable from requesters is not
   // needed because the arbiter generates its own SETUP/ACCESS sequencing.
   logic unused_penable;
   assign unused_penable = ^m_penable;

   rr_arb #(
      .MST_NUM (MST_NUM),
      .IW      (IW)
   ) u_rr_arb (
      .req     (m_psel),
      .ptr     (ptr_q),
      .gnt_oh  (win_oh),
      .gnt_idx (win_idx)
   );

   assign in_access = (state_q == StAccess);
   // A real s_pready wins over a coincident timeout.
   assign timeout   = in_access && !s_pready && (tmo_cnt_q == CW'(TMO_CYC - 1));
   assign done      = in_access && (s_pready || timeout);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         grant_oh_q <= '0;
         ptr_q      <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_oh_q <= grant_oh_d;
         ptr_q      <= ptr_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_oh_d = grant_oh_q;
      ptr_d      = ptr_q;
      tmo_cnt_d  = tmo_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (|m_psel) begin
               grant_d    = win_idx;
               grant_oh_d = win_oh;
               state_d    = StSetup;
            end
         end
         StSetup: begin
            tmo_cnt_d = '0;
            state_d   = StAccess;
         end
         StAccess: begin
            if (done) begin
               state_d = StIdle;
               ptr_d   = (grant_q == IW'(MST_NUM - 1)) ? '0 : grant_q + 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Slave request side follows the granted requester; responses are routed back
   // through the registered one-hot grant.
   always_comb begin
      s_psel    = 1'b0;
      s_penable = 1'b0;
      s_pwrite  = 1'b0;
      s_paddr   = '0;
      s_pwdata  = '0;
      s_pstrb   = '0;
      m_pready  = '0;
      m_pslverr = '0;
      m_prdata  = '0;
      if (state_q != StIdle) begin
         s_psel    = 1'b1;
         s_penable = in_access;
         s_pwrite  = m_pwrite[grant_q];
         s_paddr   = m_paddr[32*grant_q +: 32];
         s_pwdata  = m_pwdata[32*grant_q +: 32];
         s_pstrb   = m_pstrb[4*grant_q +: 4];
      end
      if (in_access) begin
         m_pready  = done ? grant_oh_q : '0;
         m_pslverr = (s_pslverr || timeout) ? grant_oh_q : '0;
         if (s_pready) begin
            m_prdata = s_prdata;
         end
      end
   end

endmodule

// File: tb/tb_intc_apb_arb.sv
// Randomized bench for intc_apb_arb against a transaction-level reference model.
module tb_intc_apb_arb;

   localparam int unsigned N   = 3;
   localparam int unsigned TMO = 4;
   localparam int unsigned NPH = 5;

   // Per-phase stimulus knobs: requester mask, psel/pready/pslverr/reset percentages.
   localparam int unsigned PH_MASK [NPH] = '{1, 3, 7, 3, 7};
   localparam int unsigned PH_SEL  [NPH] = '{100, 100, 50, 100, 60};
   localparam int unsigned PH_RDY  [NPH] = '{100, 100, 40, 0, 50};
   localparam int unsigned PH_ERR  [NPH] = '{0, 0, 20, 0, 30};
   localparam int unsigned PH_RST  [NPH] = '{0, 0, 0, 0, 3};

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      m_psel, m_penable, m_pwrite;
   logic [N*32-1:0]   m_paddr, m_pwdata;
   logic [N*4-1:0]    m_pstrb;
   logic [31:0]       m_prdata;
   logic [N-1:0]      m_pready, m_pslverr;
   logic              s_psel, s_penable, s_pwrite;
   logic [31:0]       s_paddr, s_pwdata;
   logic [3:0]        s_pstrb;
   logic [31:0]       s_prdata;
   logic              s_pready, s_pslverr;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a transfer in flight, its owner and its age in cycles
   // (age 1 is the setup cycle, age k+1 is the k-th access cycle).
   bit busy;
   int who;
   int age;
   int ptr;

   always #5 clk = ~clk;

   intc_apb_arb #(
      .MST_NUM (N),
      .TMO_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_psel    (m_psel),
      .m_penable (m_penable),
      .m_pwrite  (m_pwrite),
      .m_paddr   (m_paddr),
      .m_pwdata  (m_pwdata),
      .m_pstrb   (m_pstrb),
      .m_prdata  (m_prdata),
      .m_pready  (m_pready),
      .m_pslverr (m_pslverr),
      .s_psel    (s_psel),
      .s_penable (s_penable),
      .s_pwrite  (s_pwrite),
      .s_paddr   (s_paddr),
      .s_pwdata  (s_pwdata),
      .s_pstrb   (s_pstrb),
      .s_prdata  (s_prdata),
      .s_pready  (s_pready),
      .s_pslverr (s_pslverr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   initial begin
      logic        acc, to, fin;
      logic [6:0]  e_ctl;
      logic [31:0] e_addr, e_wdata, e_rdata;
      logic [N-1:0] e_rdy, e_err;
      int          win;

      rst       = 1'b1;
      m_psel    = '0;
      m_penable = '0;
      m_pwrite  = '0;
      m_paddr   = '0;
      m_pwdata  = '0;
      m_pstrb   = '0;
      s_prdata  = '0;
      s_pready  = 1'b0;
      s_pslverr = 1'b0;
      repeat (2) @(posedge clk);
      busy = 1'b0;
      who  = 0;
      age  = 0;
      ptr  = 0;

      for (int p = 0; p < NPH; p++) begin
         repeat (300) begin
            @(negedge clk);
            rst = ($urandom_range(99) < PH_RST[p]);
            for (int i = 0; i < N; i++) begin
               m_psel[i]           = PH_MASK[p][i] && ($urandom_range(99) < PH_SEL[p]);
               m_penable[i]        = 1'($urandom);
               m_pwrite[i]         = 1'($urandom);
               m_paddr[i*32 +: 32] = $urandom;
               m_pwdata[i*32 +: 32] = $urandom;
               m_pstrb[i*4 +: 4]   = 4'($urandom);
            end
            s_pready  = ($urandom_range(99) < PH_RDY[p]);
            s_pslverr = ($urandom_range(99) < PH_ERR[p]);
            s_prdata  = $urandom;
            #1;

            acc = busy && (age >= 2);
            to  = acc && (age - 1 == TMO) && !s_pready;
            fin = acc && (s_pready || to);
            e_ctl   = '0;
            e_addr  = '0;
            e_wdata = '0;
            e_rdata = '0;
            e_rdy   = '0;
            e_err   = '0;
            if (busy) begin
               e_ctl   = {1'b1, acc, m_pwrite[who], m_pstrb[who*4 +: 4]};
               e_addr  = m_paddr[who*32 +: 32];
               e_wdata = m_pwdata[who*32 +: 32];
            end
            if (fin) e_rdy[who] = 1'b1;
            if (acc && (s_pslverr || to)) e_err[who] = 1'b1;
            if (acc && s_pready) e_rdata = s_prdata;

            check("s_ctl", {s_psel, s_penable, s_pwrite, s_pstrb}, e_ctl);
            check("s_paddr", s_paddr, e_addr);
            check("s_pwdata", s_pwdata, e_wdata);
            check("m_pready", m_pready, e_rdy);
            check("m_pslverr", m_pslverr, e_err);
            check("m_prdata", m_prdata, e_rdata);

            win = -1;
            for (int k = 0; k < N; k++) begin
               if (win < 0 && m_psel[(ptr + k) % N]) win = (ptr + k) % N;
            end

            @(posedge clk);
            if (rst) begin
               busy = 1'b0;
               ptr  = 0;
            end else if (!busy) begin
               if (win >= 0) begin
                  busy = 1'b1;
                  who  = win;
                  age  = 1;
               end
            end else if (fin) begin
               busy = 1'b0;
               ptr  = (who + 1) % N;
            end else begin
               age++;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
